dmem_ctrl: RTL

- Owns the single data-memory port behind the retire stage.
- Buffers retired stores in a small FIFO (store buffer) and drains them to memory in order.
- Accepts one retire-time load at a time. The load is forwarded from the store buffer on an address hit; otherwise it goes to memory and tracks the response tag.
- Arbitrates the port between store drain and load issue, and signals when it has fully drained for a halt.

---
 rtl/dmem_ctrl_pkg.sv | 25 ++
 rtl/dmem_ctrl_store_buffer.sv | 86 ++++++++
 rtl/dmem_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: bus encodings, store-buffer entry and load-slot state shared by the
// data-memory controller and its store buffer.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 2
`endif
package dmem_ctrl_pkg;
  localparam int XLEN = `XLEN;
  localparam int SUPERSCALAR_WAYS = `SUPERSCALAR_WAYS;
  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } sb_entry_t;
  typedef logic [1:0] ld_state_t;
  localparam ld_state_t LD_EMPTY = 2'd0;
  localparam ld_state_t LD_PEND  = 2'd1;
  localparam ld_state_t LD_WAIT  = 2'd2;
  localparam ld_state_t LD_RESP  = 2'd3;
endpackage

// File: rtl/dmem_ctrl_store_buffer.sv
// dmem_ctrl_store_buffer: in-order store FIFO with multi-lane push, single pop and
// youngest-match forwarding over buffered plus same-cycle incoming stores.
module dmem_ctrl_store_buffer
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WAYS = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [WAYS-1:0]      i_push_valid,
  input  logic [WAYS*XLEN-1:0] i_push_addr,
  input  logic [WAYS*XLEN-1:0] i_push_data,
  input  logic                 i_pop,
  input  logic [XLEN-1:0]      i_ld_addr,
  output sb_entry_t            o_head,
  output logic [CW-1:0]        o_count,
  output logic [CW-1:0]        o_count_next,
  output logic [CW-1:0]        o_free,
  output logic                 o_hit,
  output logic [XLEN-1:0]      o_hit_data
);
  sb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_head, r_tail, w_idx;
  logic [CW-1:0]   r_count, r_free, w_space, w_npush;
  logic [WAYS-1:0] w_acc;
  logic            w_run, w_pop;
  assign w_pop = i_pop && r_count != '0;
  assign o_head = r_mem[r_head];
  assign o_count = r_count;
  assign o_free = r_free;
  assign o_count_next = r_count + w_npush - CW'(w_pop);
  // A pop in the same cycle frees a slot; lanes past the first gap or past free space drop.
  always_comb begin
    w_space = CW'(DEPTH) - r_count + CW'(w_pop);
    w_run = 1'b1;
    w_npush = '0;
    w_acc = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_run = w_run & i_push_valid[i] & (w_npush < w_space);
      w_acc[i] = w_run;
      w_npush = w_npush + CW'(w_run);
    end
  end
  always_comb begin
    o_hit = 1'b0;
    o_hit_data = '0;
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if (CW'(k) < r_count && r_mem[w_idx].valid && r_mem[w_idx].addr == i_ld_addr) begin
        o_hit = 1'b1;
        o_hit_data = r_mem[w_idx].data;
      end
    end
    for (int i = 0; i < WAYS; i++)
      if (w_acc[i] && i_push_addr[i*XLEN +: XLEN] == i_ld_addr) begin
        o_hit = 1'b1;
        o_hit_data = i_push_data[i*XLEN +: XLEN];
      end
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_free <= CW'(DEPTH);
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (w_pop) begin
        r_mem[r_head].valid <= 1'b0;
        r_head <= r_head + PW'(1);
      end
      for (int i = 0; i < WAYS; i++)
        if (w_acc[i])
          r_mem[r_tail + PW'(i)] <= {1'b1, i_push_addr[i*XLEN +: XLEN], i_push_data[i*XLEN +: XLEN]};
      r_tail <= r_tail + w_npush[PW-1:0];
      r_count <= o_count_next;
      r_free <= CW'(DEPTH) - o_count_next;
    end
  end
  a_push_legal: assert property (@(posedge i_clock) disable iff (!i_reset)
    ((i_push_valid & (i_push_valid + WAYS'(1))) == '0) && $countones(i_push_valid) <= int'(w_space));
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: owns the data-memory port; drains the store buffer in order, serves one
// retire-time load (forwarded or from memory) and reports drained for halt.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int DRAIN_THRESH = 3,
  parameter int WAYS = SUPERSCALAR_WAYS,
  localparam int CW = $clog2(SB_DEPTH + 1)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [WAYS-1:0]      i_st_in_valid,
  input  logic [WAYS*XLEN-1:0] i_st_in_addr,
  input  logic [WAYS*XLEN-1:0] i_st_in_data,
  output logic [CW-1:0]        o_sb_free,
  input  logic                 i_ld_req_valid,
  input  logic [XLEN-1:0]      i_ld_req_addr,
  output logic                 o_ld_req_ready,
  output logic                 o_ld_resp_valid,
  output logic [XLEN-1:0]      o_ld_resp_data,
  input  logic                 i_halt_req,
  output logic                 o_drained,
  output logic [1:0]           o_proc2Dmem_command,
  output logic [XLEN-1:0]      o_proc2Dmem_addr,
  output logic [XLEN-1:0]      o_proc2Dmem_data,
  input  logic [3:0]           i_mem2proc_response,
  input  logic [XLEN-1:0]      i_mem2proc_data,
  input  logic [3:0]           i_mem2proc_tag
);
  sb_entry_t       w_head;
  logic [CW-1:0]   w_count, w_count_next;
  logic            w_hit, w_st_sel, w_ld_sel, w_accept, w_halt_next;
  logic [XLEN-1:0] w_hit_data, r_ld_addr, r_resp_data;
  ld_state_t       r_state, w_state_next;
  logic [3:0]      r_tag;
  logic            r_halt, r_drained;
  dmem_ctrl_store_buffer #(.DEPTH(SB_DEPTH), .WAYS(WAYS)) u_sb (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_push_valid(i_st_in_valid), .i_push_addr(i_st_in_addr), .i_push_data(i_st_in_data),
    .i_pop(w_st_sel && w_accept), .i_ld_addr(i_ld_req_addr),
    .o_head(w_head), .o_count(w_count), .o_count_next(w_count_next), .o_free(o_sb_free),
    .o_hit(w_hit), .o_hit_data(w_hit_data)
  );
  // Stores yield to a pending load only while the buffer is shallow and no halt is draining.
  assign w_st_sel = w_head.valid && (w_count >= CW'(DRAIN_THRESH) || r_halt || r_state != LD_PEND);
  assign w_ld_sel = !w_st_sel && r_state == LD_PEND;
  assign w_accept = i_mem2proc_response != 4'd0;
  assign w_halt_next = r_halt | i_halt_req;
  assign o_proc2Dmem_command = w_st_sel ? BUS_STORE : w_ld_sel ? BUS_LOAD : BUS_NONE;
  assign o_proc2Dmem_addr = w_st_sel ? w_head.addr : w_ld_sel ? r_ld_addr : '0;
  assign o_proc2Dmem_data = w_st_sel ? w_head.data : '0;
  assign o_ld_req_ready = r_state == LD_EMPTY;
  assign o_ld_resp_valid = r_state == LD_RESP;
  assign o_ld_resp_data = r_resp_data;
  assign o_drained = r_drained;
  always_comb
    w_state_next = r_state == LD_EMPTY ? (i_ld_req_valid ? (w_hit ? LD_RESP : LD_PEND) : LD_EMPTY)
                 : r_state == LD_PEND  ? (w_ld_sel && w_accept ? LD_WAIT : LD_PEND)
                 : r_state == LD_WAIT  ? (i_mem2proc_tag != 4'd0 && i_mem2proc_tag == r_tag ? LD_RESP : LD_WAIT)
                 : LD_EMPTY;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= LD_EMPTY;
      r_halt <= 1'b0;
      r_drained <= 1'b0;
      r_tag <= '0;
      r_ld_addr <= '0;
      r_resp_data <= '0;
    end else begin
      r_state <= w_state_next;
      r_halt <= w_halt_next;
      r_drained <= w_halt_next && w_count_next == '0 && w_state_next == LD_EMPTY;
      if (r_state == LD_EMPTY && i_ld_req_valid) begin
        if (w_hit) r_resp_data <= w_hit_data;
        else r_ld_addr <= i_ld_req_addr;
      end
      if (r_state == LD_PEND && w_ld_sel && w_accept) r_tag <= i_mem2proc_response;
      if (r_state == LD_WAIT && w_state_next == LD_RESP) r_resp_data <= i_mem2proc_data;
    end
  end
endmodule
